signed_add_with_overflow: RTL and testbench
===========================================

Name: signed_add_with_overflow

Overview:
- Two's-complement adder for two WIDTH-bit signed operands. Produces the wrapped sum and a signed-overflow flag.
- The core path is purely combinational, for use inside arithmetic datapaths.
- Also provides a valid-qualified registered copy of the result, a sticky overflow flag and a saturating overflow-event counter for status/debug.

Parameters:
- WIDTH, 4, operand and sum width in bits (minimum 2).
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- sum  output  WIDTH  combinational signed sum a+b, wrapped modulo 2^WIDTH.
- overflow  output  1  combinational signed-overflow flag.
- in_valid  input  1  qualifies a/b for the registered path.
- out_valid  output  1  registered sum_q/overflow_q are valid.
- sum_q  output  WIDTH  registered sum.
- overflow_q  output  1  registered overflow.
- ovf_sticky  output  1  set on any valid overflow; held until cleared.
- ovf_clear  input  1  synchronous clear of ovf_sticky and ovf_count.
- ovf_count  output  CNT_W  number of valid overflow events; saturates at all-ones.

Behaviour:
- Combinational path (no clock dependence; settles within the same delta cycle):
  - sum = low WIDTH bits of a+b; the wrapped value is output even when overflow=1.
  - overflow = 1 iff sign(a)==sign(b) and sign(sum)!=sign(a).
  - Opposite-sign operands never overflow.
  - Both outputs are always 0/1, never X/Z, for known inputs.
- Registered path, 1-cycle latency:
  - On a rising clk edge with in_valid=1: sum_q<=sum, overflow_q<=overflow, out_valid<=1.
  - On an edge with in_valid=0: out_valid<=0; sum_q/overflow_q hold their previous values.
- Sticky flag and counter:
  - ovf_sticky: set on an edge where in_valid&&overflow; otherwise holds.
  - ovf_count: increments by 1 on each such edge; stops at 2^CNT_W-1 (no wrap).
  - ovf_clear=1 has priority over a simultaneous overflow event: sticky<=0, count<=0 on that edge. The overflow in that same cycle is discarded.
- Reset:
  - rst_n low asynchronously forces out_valid, sum_q, overflow_q, ovf_sticky and ovf_count to 0, regardless of clk.
  - Release is synchronised by the integrator.
  - The combinational sum/overflow outputs are unaffected by reset.
  - Reset asserted mid-stream drops any in-flight result (out_valid=0 on the next cycle after release, unless in_valid=1).
- No backpressure: out_valid is a one-cycle pulse per accepted input.

Optional Feature:
- Macro SIGNED_ADD_SATURATE_EN.
- When defined:
  - Adds output sat_sum (WIDTH). It is combinational: equals sum when overflow=0.
  - On overflow it clamps to the max positive value (0111..1) when both operands are non-negative, and to the min negative value (1000..0) when both are negative.
  - sum_q registers sat_sum instead of sum.
- When undefined:
  - The port does not exist.
  - sum_q registers the wrapped sum.
- The combinational sum/overflow outputs are identical in both builds.

Test Plan:
- Combinational, no clock: 0+0 -> sum 0, ovf 0; 1+(-2) -> -1, ovf 0; -1+(-2) -> -3, ovf 0; 1+(-1) -> 0, ovf 0.
- Positive overflow: 4+7 -> ovf 1, sum bits 1011 (-5); 3+5 -> ovf 1, sum -8; 4+4 -> ovf 1, sum -8; 6+3 -> ovf 1.
- Negative boundary: -4+(-4) -> sum -8, ovf 0; -4+(-7) -> ovf 1, sum 5; -3+(-6) -> ovf 1, sum 7; -3+(-5) -> -8, ovf 0.
- Mixed signs: 4+(-7) -> -3; -7+4 -> -3; 7+(-4) -> 3; -6+3 -> -3; all ovf 0.
- Registered/sticky: pulse in_valid with 7+4, then with 1+1.
  - Cycle+1: sum_q=-5, overflow_q=1, out_valid=1.
  - Next cycle: sum_q=2, overflow_q=0.
  - ovf_sticky=1, ovf_count=1 throughout.
  - Assert ovf_clear together with in_valid on -7+(-4) -> sticky 0, count 0.
  - Drop rst_n mid-stream -> all registered outputs 0 immediately.
- With SIGNED_ADD_SATURATE_EN: 4+7 -> sat_sum 7; -4+(-7) -> sat_sum -8; 1+2 -> sat_sum 3.
- Counter saturation: with CNT_W=2, 5 consecutive overflow events -> ovf_count=3.

Source files
------------

// File: rtl/signed_add_with_overflow.sv
// signed_add_with_overflow: two's-complement WIDTH-bit adder with a combinational
// wrapped sum and signed-overflow flag, plus a valid-qualified registered copy,
// a sticky overflow flag and a saturating overflow-event counter.
// Optional build macro SIGNED_ADD_SATURATE_EN adds a clamped sat_sum output and
// makes sum_q register the clamped value instead of the wrapped one.
module signed_add_with_overflow #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             overflow_q,
  output logic             ovf_sticky,
  input  logic             ovf_clear,
  output logic [CNT_W-1:0] ovf_count
`ifdef SIGNED_ADD_SATURATE_EN
  ,
  output logic [WIDTH-1:0] sat_sum
`endif
);

  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;
  logic [WIDTH-1:0] w_sum_reg;
  logic             w_ovf_event;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_overflow;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  // Wrapped sum; overflow only when like-signed operands yield an opposite-signed result.
  always_comb begin
    w_sum      = a + b;
    w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  end

`ifdef SIGNED_ADD_SATURATE_EN
  logic [WIDTH-1:0] w_sat_sum;

  // Clamp toward the operands' common sign when the sum overflows.
  always_comb begin
    w_sat_sum = w_sum;
    if (w_overflow) begin
      w_sat_sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign sat_sum   = w_sat_sum;
  assign w_sum_reg = w_sat_sum;
`else
  assign w_sum_reg = w_sum;
`endif

  assign sum         = w_sum;
  assign overflow    = w_overflow;
  assign w_ovf_event = in_valid && w_overflow;

  // Capture result on accepted input; out_valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_sum      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum      <= w_sum_reg;
        r_overflow <= w_overflow;
      end
    end
  end

  // Sticky flag and saturating event counter; clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (ovf_clear) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (w_ovf_event) begin
      r_sticky <= 1'b1;
      if (r_count != {CNT_W{1'b1}}) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_valid;
  assign sum_q      = r_sum;
  assign overflow_q = r_overflow;
  assign ovf_sticky = r_sticky;
  assign ovf_count  = r_count;

endmodule

// File: tb/tb_signed_add_with_overflow.sv
// Directed bench for signed_add_with_overflow (WIDTH=4). A second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_signed_add_with_overflow;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic       ovf_clear;

  logic [3:0] sum, sum_q;
  logic       overflow, out_valid, overflow_q, ovf_sticky;
  logic [7:0] ovf_count;

  logic [3:0] sum2, sum_q2;
  logic       overflow2, out_valid2, overflow_q2, ovf_sticky2;
  logic [1:0] ovf_count2;

`ifdef SIGNED_ADD_SATURATE_EN
  logic [3:0] sat_sum, sat_sum2;
`endif

  int n_vec;
  int n_fail;

  // Scoreboard of {registered sum, registered overflow}
  logic [4:0] sb_q[$];

  logic       exp_sticky;
  logic [7:0] exp_cnt8;
  logic [1:0] exp_cnt2;
  logic [3:0] last_sum;
  logic       last_ovf;

  signed_add_with_overflow #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .sum        (sum),
    .overflow   (overflow),
    .in_valid   (in_valid),
    .out_valid  (out_valid),
    .sum_q      (sum_q),
    .overflow_q (overflow_q),
    .ovf_sticky (ovf_sticky),
    .ovf_clear  (ovf_clear),
    .ovf_count  (ovf_count)
`ifdef SIGNED_ADD_SATURATE_EN
    ,
    .sat_sum    (sat_sum)
`endif
  );

  signed_add_with_overflow #(.WIDTH(4), .CNT_W(2)) u_dut_c2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .sum        (sum2),
    .overflow   (overflow2),
    .in_valid   (in_valid),
    .out_valid  (out_valid2),
    .sum_q      (sum_q2),
    .overflow_q (overflow_q2),
    .ovf_sticky (ovf_sticky2),
    .ovf_clear  (ovf_clear),
    .ovf_count  (ovf_count2)
`ifdef SIGNED_ADD_SATURATE_EN
    ,
    .sat_sum    (sat_sum2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: add as true integers, then range-check and truncate.
  task automatic model(input logic [3:0] x, input logic [3:0] y,
                       output logic [3:0] s, output logic o, output logic [3:0] sat);
    int xi, yi, r;
    xi  = $signed(x);
    yi  = $signed(y);
    r   = xi + yi;
    o   = (r > 7) || (r < -8);
    s   = r[3:0];
    sat = (r > 7) ? 4'h7 : ((r < -8) ? 4'h8 : r[3:0]);
  endtask

  task automatic comb_check(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] es, esat;
    logic       eo;
    model(x, y, es, eo, esat);
    a = x;
    b = y;
    #1;
    chk("comb_sum", sum, es);
    chk("comb_ovf", overflow, eo);
`ifdef SIGNED_ADD_SATURATE_EN
    chk("comb_sat_sum", sat_sum, esat);
`endif
  endtask

  // One clock: drive on negedge, update model, compare #1 after posedge.
  task automatic cycle(input logic [3:0] x, input logic [3:0] y, input logic v, input logic clr);
    logic [3:0] es, esat, ereg;
    logic       eo;
    logic [4:0] ent;
    @(negedge clk);
    a         = x;
    b         = y;
    in_valid  = v;
    ovf_clear = clr;
    model(x, y, es, eo, esat);
`ifdef SIGNED_ADD_SATURATE_EN
    ereg = esat;
`else
    ereg = es;
`endif
    if (v) sb_q.push_back({ereg, eo});
    if (clr) begin
      exp_sticky = 1'b0;
      exp_cnt8   = '0;
      exp_cnt2   = '0;
    end else if (v && eo) begin
      exp_sticky = 1'b1;
      if (exp_cnt8 != 8'hff) exp_cnt8 = exp_cnt8 + 8'd1;
      if (exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 2'd1;
    end
    @(posedge clk);
    #1;
    if (v) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        ent      = sb_q.pop_front();
        last_sum = ent[4:1];
        last_ovf = ent[0];
      end
      chk("out_valid_pulse", out_valid, 1'b1);
    end else begin
      chk("out_valid_idle", out_valid, 1'b0);
    end
    chk("sum_q", sum_q, last_sum);
    chk("overflow_q", overflow_q, last_ovf);
    chk("ovf_sticky", ovf_sticky, exp_sticky);
    chk("ovf_count", ovf_count, exp_cnt8);
    chk("ovf_count_c2", ovf_count2, exp_cnt2);
  endtask

  task automatic regs_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_sum_q"}, sum_q, 4'h0);
    chk({tag, "_overflow_q"}, overflow_q, 1'b0);
    chk({tag, "_sticky"}, ovf_sticky, 1'b0);
    chk({tag, "_count"}, ovf_count, 8'h00);
    chk({tag, "_count_c2"}, ovf_count2, 2'b00);
  endtask

  initial begin
    n_vec      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    a          = 4'h0;
    b          = 4'h0;
    in_valid   = 1'b0;
    ovf_clear  = 1'b0;
    exp_sticky = 1'b0;
    exp_cnt8   = '0;
    exp_cnt2   = '0;
    last_sum   = '0;
    last_ovf   = 1'b0;

    #2;
    regs_zero("reset");

    // Combinational path, checked while still in reset.
    comb_check(4'd0, 4'd0);
    comb_check(4'd1, 4'hE);   // 1 + -2
    comb_check(4'hF, 4'hE);   // -1 + -2
    comb_check(4'd1, 4'hF);   // 1 + -1
    comb_check(4'd4, 4'd7);
    chk("pos_ovf_4p7_sum", sum, 4'b1011);
    chk("pos_ovf_4p7_flag", overflow, 1'b1);
    comb_check(4'd3, 4'd5);
    comb_check(4'd4, 4'd4);
    chk("pos_ovf_4p4_sum", sum, 4'h8);
    comb_check(4'd6, 4'd3);
    comb_check(4'hC, 4'hC);   // -4 + -4 = -8, no overflow
    chk("neg_bound_sum", sum, 4'h8);
    chk("neg_bound_flag", overflow, 1'b0);
    comb_check(4'hC, 4'h9);   // -4 + -7
    chk("neg_ovf_sum", sum, 4'd5);
    comb_check(4'hD, 4'hA);   // -3 + -6
    comb_check(4'hD, 4'hB);   // -3 + -5
    comb_check(4'd4, 4'h9);   // 4 + -7
    comb_check(4'h9, 4'd4);
    comb_check(4'd7, 4'hC);
    comb_check(4'hA, 4'd3);
`ifdef SIGNED_ADD_SATURATE_EN
    comb_check(4'd4, 4'd7);
    chk("sat_pos_clamp", sat_sum, 4'h7);
    comb_check(4'hC, 4'h9);
    chk("sat_neg_clamp", sat_sum, 4'h8);
    comb_check(4'd1, 4'd2);
    chk("sat_pass", sat_sum, 4'd3);
`endif
    regs_zero("still_reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Registered path and sticky/count.
    cycle(4'd7, 4'd4, 1'b1, 1'b0);
`ifndef SIGNED_ADD_SATURATE_EN
    chk("reg_7p4_sum", sum_q, 4'hB);
`endif
    cycle(4'd1, 4'd1, 1'b1, 1'b0);
    chk("reg_1p1_sum", sum_q, 4'd2);
    chk("count_after_two", ovf_count, 8'd1);
    cycle(4'd0, 4'd0, 1'b0, 1'b0);   // idle: hold sum_q
    cycle(4'h9, 4'hC, 1'b1, 1'b1);   // clear beats simultaneous overflow
    chk("clear_sticky", ovf_sticky, 1'b0);
    chk("clear_count", ovf_count, 8'd0);

    // Counter saturation on the CNT_W=2 instance.
    for (int i = 0; i < 5; i++) cycle(4'd5, 4'd5, 1'b1, 1'b0);
    chk("sat_count_c2", ovf_count2, 2'b11);
    chk("sat_count_c8", ovf_count, 8'd5);
    cycle(4'd2, 4'd3, 1'b0, 1'b0);

    // Mid-stream asynchronous reset.
    @(negedge clk);
    a        = 4'd6;
    b        = 4'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    regs_zero("async_reset");
    sb_q.delete();
    exp_sticky = 1'b0;
    exp_cnt8   = '0;
    exp_cnt2   = '0;
    last_sum   = '0;
    last_ovf   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    cycle(4'd0, 4'd0, 1'b0, 1'b0);
    cycle(4'd3, 4'd2, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
